// File: rtl/stream_pattern_src.sv
// Burst pattern source: emits len beats of an incrementing payload starting at seed,
// with optional idle gaps between beats, on a valid/ready stream.
module stream_pattern_src #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned LenWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [LenWidth-1:0]  len_i,
    input  logic [LenWidth-1:0]  gap_i,
    input  logic [DataWidth-1:0] seed_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 last_o,
    output logic                 busy_o,
    output logic                 done_o
);

    typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

    state_e               state_q;
    logic [LenWidth-1:0]  remaining_q;
    logic [LenWidth-1:0]  gap_len_q;
    logic [LenWidth-1:0]  gap_cnt_q;
    logic                 valid_q;
    logic                 last_q;
    logic                 busy_q;
    logic                 done_q;
    logic [DataWidth-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            gap_len_q   <= '0;
            gap_cnt_q   <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            data_q      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        gap_len_q <= gap_i;
                        busy_q    <= 1'b1;
                        if (len_i != '0) begin
                            state_q     <= StSend;
                            valid_q     <= 1'b1;
                            data_q      <= seed_i;
                            remaining_q <= len_i;
                            last_q      <= (len_i == LenWidth'(1));
                        end else begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StSend: begin
                    // Outputs only move on a handshake, so a stall holds them stable.
                    if (ready_i) begin
                        if (remaining_q == LenWidth'(1)) begin
                            state_q <= StDone;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            remaining_q <= remaining_q - LenWidth'(1);
                            if (gap_len_q == '0) begin
                                data_q <= data_q + DataWidth'(1);
                                last_q <= (remaining_q == LenWidth'(2));
                            end else begin
                                state_q   <= StGap;
                                valid_q   <= 1'b0;
                                last_q    <= 1'b0;
                                gap_cnt_q <= gap_len_q;
                            end
                        end
                    end
                end
                StGap: begin
                    // Payload advances on gap exit so the next beat is previous + 1.
                    if (gap_cnt_q == LenWidth'(1)) begin
                        state_q <= StSend;
                        valid_q <= 1'b1;
                        data_q  <= data_q + DataWidth'(1);
                        last_q  <= (remaining_q == LenWidth'(1));
                    end else begin
                        gap_cnt_q <= gap_cnt_q - LenWidth'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule
